// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bus bundle between two requesters, the arbiter and a
// single-port memory.
//   fetch : if_req, if_addr (to arbiter); if_ready, if_rdata (from arbiter)
//   data  : d_req, d_we, d_addr, d_wdata (to arbiter); d_ready, d_rdata (from arbiter)
//   memory: mem_en, mem_we, mem_addr, mem_wdata (from arbiter); mem_rdata (to arbiter)
//   status: busy (from arbiter)
// Modport slave is the arbiter's view; modport master is the requester/memory side.
interface mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_ready, if_rdata, d_ready, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_ready, if_rdata, d_ready, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-port memory between an instruction-fetch
// requester and a load/store requester. Data requests win by default.
// Ports:
//   clock  : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : mem_arbiter_if.slave (fetch, data, memory and busy signals)
// Parameter:
//   STARVE_LIMIT : consecutive data grants tolerated while fetch waits (1..15),
//                  used only when the fairness build is enabled.
// Build option:
//   ARB_FAIRNESS_EN : when defined, a starvation counter forces a fetch grant
//                     after STARVE_LIMIT data grants; when undefined, strict
//                     data priority.
// Transaction: IDLE samples requests -> GNT (mem_en high for one cycle)
// -> RSP (ready pulse for one cycle) -> IDLE.
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic         clock,
   input  logic         reset,
   mem_arbiter_if.slave bus
);

   typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, RSP_I, RSP_D} state_t;

   localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

   if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15) begin : g_limit_check
      $error("mem_arbiter: STARVE_LIMIT must be within 1..15");
   end

   state_t      state_q;
   logic        mem_en_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic        if_ready_q;
   logic [31:0] if_rdata_q;
   logic        d_ready_q;
   logic [31:0] d_rdata_q;
   logic        busy_q;
   logic        fetch_turn;   // fairness override: grant fetch ahead of data

`ifdef ARB_FAIRNESS_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_q;

   assign fetch_turn = bus.if_req && (starve_q == LIMIT);

   // Counts data grants taken while fetch is waiting; any IDLE cycle without
   // a fetch request, or a fetch grant, restarts the count.
   always_ff @(posedge clock) begin
      if (reset) begin
         starve_q <= '0;
      end else if (state_q == IDLE) begin
         if (!bus.if_req) begin
            starve_q <= '0;
         end else if (bus.d_req && !fetch_turn) begin
            starve_q <= starve_q + 4'd1;
         end else begin
            starve_q <= '0;
         end
      end
   end
`else
   assign fetch_turn = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ready_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_ready_q   <= 1'b0;
         d_rdata_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // Request fields are latched here so the memory sees stable
               // values even if the requester drops its request after grant.
               if (bus.d_req && !fetch_turn) begin
                  state_q     <= GNT_D;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= bus.d_we;
                  mem_addr_q  <= bus.d_addr & ADDR_MASK;
                  mem_wdata_q <= bus.d_wdata;
                  busy_q      <= 1'b1;
               end else if (bus.if_req) begin
                  state_q     <= GNT_I;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= bus.if_addr & ADDR_MASK;
                  busy_q      <= 1'b1;
               end
            end
            GNT_I: begin
               state_q    <= RSP_I;
               mem_en_q   <= 1'b0;
               mem_we_q   <= 1'b0;
               if_ready_q <= 1'b1;
               if_rdata_q <= bus.mem_rdata;
            end
            GNT_D: begin
               state_q   <= RSP_D;
               mem_en_q  <= 1'b0;
               mem_we_q  <= 1'b0;
               d_ready_q <= 1'b1;
               // mem_we_q still holds the granted access type on this edge.
               if (!mem_we_q) begin
                  d_rdata_q <= bus.mem_rdata;
               end
            end
            RSP_I: begin
               state_q    <= IDLE;
               if_ready_q <= 1'b0;
               busy_q     <= 1'b0;
            end
            RSP_D: begin
               state_q   <= IDLE;
               d_ready_q <= 1'b0;
               busy_q    <= 1'b0;
            end
            default: begin
               state_q    <= IDLE;
               mem_en_q   <= 1'b0;
               mem_we_q   <= 1'b0;
               if_ready_q <= 1'b0;
               d_ready_q  <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_ready  = if_ready_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_ready   = d_ready_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed stimulus with a scoreboard. Stimulus pushes the
// expected memory accesses and ready responses (with their cycle numbers)
// into queues; a monitor on the falling edge pops and compares whenever the
// DUT shows mem_en or a ready pulse. Works for both builds (ARB_FAIRNESS_EN).
module tb_mem_arbiter;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int unsigned cyc;
   } mem_exp_t;

   typedef struct {
      bit          is_d;
      logic [31:0] rdata;
      int unsigned cyc;
   } rsp_exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned failures = 0;
   logic [31:0] exp_drdata = '0;

   mem_exp_t mem_q[$];
   rsp_exp_t rsp_q[$];
   logic [31:0] mem [logic [31:0]];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter_if bus();

   mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_mem(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input int unsigned c);
      mem_exp_t e;
      e.we = we; e.addr = a; e.wdata = wd; e.cyc = c;
      mem_q.push_back(e);
   endtask

   task automatic exp_rsp(input bit is_d, input logic [31:0] rd, input int unsigned c);
      rsp_exp_t e;
      e.is_d = is_d; e.rdata = rd; e.cyc = c;
      rsp_q.push_back(e);
   endtask

   // Memory model: stores on the falling edge of a write grant; read data is
   // presented during the grant cycle so it is stable at the closing edge.
   always @(negedge clk) begin
      if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) mem[bus.mem_addr] = bus.mem_wdata;
      bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'hDEAD_0000;
   end

   // Monitor / scoreboard consumer.
   always @(negedge clk) begin
      if (bus.mem_en === 1'b1) begin
         if (mem_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL mem_unexpected: got access addr 0x%08h at cycle %0d, required none",
                     bus.mem_addr, cyc);
         end else begin
            mem_exp_t e;
            e = mem_q.pop_front();
            chk("mem_cycle", cyc, e.cyc);
            chk("mem_we", {31'b0, bus.mem_we}, {31'b0, e.we});
            chk("mem_addr", bus.mem_addr, e.addr);
            if (e.we) chk("mem_wdata", bus.mem_wdata, e.wdata);
         end
         chk("busy_in_grant", {31'b0, bus.busy}, 32'd1);
      end else if (bus.mem_en === 1'b0) begin
         chk("mem_we_idle", {31'b0, bus.mem_we}, 32'd0);
      end
      if (bus.if_ready === 1'b1 || bus.d_ready === 1'b1) begin
         chk("ready_exclusive", {31'b0, bus.if_ready & bus.d_ready}, 32'd0);
         if (rsp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp_unexpected: got if_ready=%0b d_ready=%0b at cycle %0d, required none",
                     bus.if_ready, bus.d_ready, cyc);
         end else begin
            rsp_exp_t e;
            e = rsp_q.pop_front();
            chk("rsp_cycle", cyc, e.cyc);
            chk("rsp_is_data", {31'b0, bus.d_ready}, {31'b0, e.is_d});
            if (e.is_d) chk("d_rdata", bus.d_rdata, e.rdata);
            else        chk("if_rdata", bus.if_rdata, e.rdata);
         end
      end
   end

   task automatic fetch_req(input logic [31:0] a, input int unsigned n, input bit drop_early);
      int unsigned seen = 0;
      bus.if_req = 1'b1;
      bus.if_addr = a;
      if (drop_early) begin
         step();
         bus.if_req = 1'b0;
      end
      for (int t = 0; t < 400 && seen < n; t++) begin
         step();
         if (bus.if_ready === 1'b1) seen++;
      end
      bus.if_req = 1'b0;
      chk("fetch_pulses", seen, n);
   endtask

   task automatic data_req(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input int unsigned n);
      int unsigned seen = 0;
      bus.d_req = 1'b1;
      bus.d_we = we;
      bus.d_addr = a;
      bus.d_wdata = wd;
      for (int t = 0; t < 400 && seen < n; t++) begin
         step();
         if (bus.d_ready === 1'b1) seen++;
      end
      bus.d_req = 1'b0;
      chk("data_pulses", seen, n);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_if_ready"},  {31'b0, bus.if_ready}, 32'd0);
      chk({tag, "_d_ready"},   {31'b0, bus.d_ready},  32'd0);
      chk({tag, "_if_rdata"},  bus.if_rdata,          32'd0);
      chk({tag, "_d_rdata"},   bus.d_rdata,           32'd0);
      chk({tag, "_mem_en"},    {31'b0, bus.mem_en},   32'd0);
      chk({tag, "_mem_we"},    {31'b0, bus.mem_we},   32'd0);
      chk({tag, "_mem_addr"},  bus.mem_addr,          32'd0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata,         32'd0);
      chk({tag, "_busy"},      {31'b0, bus.busy},     32'd0);
   endtask

   task automatic idle_gap();
      step();
      chk("busy_idle", {31'b0, bus.busy}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned k;
      int unsigned g;
      mem[32'h0000_0008] = 32'h0010_0093;
      mem[32'h0000_0010] = 32'h1111_2222;
      mem[32'h0000_0020] = 32'h3333_4444;
      mem[32'h0000_0104] = 32'hCAFE_0104;
      mem[32'h0000_0200] = 32'h1234_5678;
      // Requests asserted during reset must be ignored.
      bus.if_req = 1'b1; bus.if_addr = 32'h8;
      bus.d_req = 1'b1;  bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'h5555_AAAA;
      bus.mem_rdata = '0;
      rst = 1'b1;
      repeat (4) step();
      check_reset_vals("reset");
      bus.if_req = 1'b0;
      bus.d_req = 1'b0;
      rst = 1'b0;
      idle_gap();

      // Fetch from 0x8.
      k = cyc;
      exp_mem(1'b0, 32'h8, '0, k + 1);
      exp_rsp(1'b0, 32'h0010_0093, k + 2);
      fetch_req(32'h8, 1, 1'b0);
      idle_gap();

      // Store to unaligned 0xFF6; d_rdata stays at its previous value.
      k = cyc;
      exp_mem(1'b1, 32'h0FF4, 32'hDEAD_BEEF, k + 1);
      exp_rsp(1'b1, exp_drdata, k + 2);
      data_req(1'b1, 32'h0FF6, 32'hDEAD_BEEF, 1);
      idle_gap();

      // Load back through a different unaligned byte address.
      k = cyc;
      exp_drdata = 32'hDEAD_BEEF;
      exp_mem(1'b0, 32'h0FF4, '0, k + 1);
      exp_rsp(1'b1, exp_drdata, k + 2);
      data_req(1'b0, 32'h0FF7, 32'h0, 1);
      idle_gap();

      // Fetch request withdrawn during its grant still completes.
      k = cyc;
      exp_mem(1'b0, 32'h104, '0, k + 1);
      exp_rsp(1'b0, 32'hCAFE_0104, k + 2);
      fetch_req(32'h104, 1, 1'b1);
      idle_gap();

      // Fetch held past its ready pulse is served again, 3 cycles later.
      k = cyc;
      exp_mem(1'b0, 32'h200, '0, k + 1);
      exp_rsp(1'b0, 32'h1234_5678, k + 2);
      exp_mem(1'b0, 32'h200, '0, k + 4);
      exp_rsp(1'b0, 32'h1234_5678, k + 5);
      fetch_req(32'h203, 2, 1'b0);
      idle_gap();

      // Simultaneous requests: data first, fetch follows.
      k = cyc;
      exp_drdata = 32'h3333_4444;
      exp_mem(1'b0, 32'h20, '0, k + 1);
      exp_rsp(1'b1, exp_drdata, k + 2);
      exp_mem(1'b0, 32'h10, '0, k + 4);
      exp_rsp(1'b0, 32'h1111_2222, k + 5);
      fork
         data_req(1'b0, 32'h22, 32'h0, 1);
         fetch_req(32'h10, 1, 1'b0);
      join
      idle_gap();

      // Continuous stores with a waiting fetch: 33 store grants (~100 cycles).
      k = cyc;
      g = k + 1;
      for (int j = 0; j < 33; j++) begin
`ifdef ARB_FAIRNESS_EN
         if (j == 4) begin
            exp_mem(1'b0, 32'h10, '0, g);
            exp_rsp(1'b0, 32'h1111_2222, g + 1);
            g += 3;
         end
`endif
         exp_mem(1'b1, 32'h40, 32'h0BAD_F00D, g);
         exp_rsp(1'b1, exp_drdata, g + 1);
         g += 3;
      end
`ifndef ARB_FAIRNESS_EN
      exp_mem(1'b0, 32'h10, '0, g);
      exp_rsp(1'b0, 32'h1111_2222, g + 1);
`endif
      fork
         data_req(1'b1, 32'h40, 32'h0BAD_F00D, 33);
         fetch_req(32'h10, 1, 1'b0);
      join
      idle_gap();

      // Reset during the grant cycle of a load aborts it without a ready pulse.
      k = cyc;
      exp_mem(1'b0, 32'h0FF4, '0, k + 1);
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0FF4; bus.d_wdata = '0;
      step();
      chk("abort_in_grant", {31'b0, bus.mem_en}, 32'd1);
      rst = 1'b1;
      bus.d_req = 1'b0;
      step();
      check_reset_vals("abort");
      rst = 1'b0;
      exp_drdata = '0;
      idle_gap();

      // Recovery after the aborted transaction.
      k = cyc;
      exp_mem(1'b0, 32'h8, '0, k + 1);
      exp_rsp(1'b0, 32'h0010_0093, k + 2);
      fetch_req(32'h8, 1, 1'b0);
      repeat (5) step();

      chk("mem_queue_drained", mem_q.size(), 32'd0);
      chk("rsp_queue_drained", rsp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
